// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_pkg
//  Purpose  : Shared types, default sizes and write-priority helper for the
//             multiport register file.
//  Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int RF_RFW = 5;
    localparam int RF_DW  = 32;
    localparam int RF_NR  = 2;
    localparam int RF_NW  = 1;

    // Widest write-port set the priority helper has to arbitrate.
    localparam int RF_MAX_NW = 2;
    localparam int RF_PIDX_W = 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

    // hit[k] flags write port k as targeting the address of interest; the
    // highest flagged index is the one whose data lands in the array.
    function automatic logic [RF_PIDX_W-1:0] rf_win_port(input logic [RF_MAX_NW-1:0] hit);
        logic [RF_PIDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < RF_MAX_NW; k++) begin
            if (hit[k]) idx = RF_PIDX_W'(k);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_read_sel.sv
`default_nettype none
// ============================================================================
//  Module   : rf_read_sel
//  Purpose  : One read port: x0 and not-ready masking, plus same-cycle write
//             bypass when RF_BYPASS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_read_sel
    import rf_pkg::*;
#(
    parameter int RFW = RF_RFW,
    parameter int DW  = RF_DW,
    parameter int NW  = RF_NW
) (
    input  logic              ready,
    input  logic [RFW-1:0]    raddr,
    input  logic [DW-1:0]     rf_q,
`ifdef RF_BYPASS_EN
    input  logic [NW-1:0]     we,
    input  logic [NW*RFW-1:0] waddr,
    input  logic [NW*DW-1:0]  wdata,
`endif
    output logic [DW-1:0]     rdata
);

`ifdef RF_BYPASS_EN
    logic [RF_MAX_NW-1:0] w_hit;
    logic [RF_PIDX_W-1:0] w_win;
    logic [DW-1:0]        w_byp;

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < NW; k++) begin
            w_hit[k] = we[k] && (waddr[k*RFW +: RFW] == raddr);
        end
        w_win = rf_win_port(w_hit);
        w_byp = '0;
        for (int k = 0; k < NW; k++) begin
            if (RF_PIDX_W'(k) == w_win) w_byp = wdata[k*DW +: DW];
        end
    end

    always_comb begin
        if (!ready || (raddr == '0)) begin
            rdata = '0;
        end else if (|w_hit) begin
            rdata = w_byp;
        end else begin
            rdata = rf_q;
        end
    end
`else
    always_comb begin
        if (!ready || (raddr == '0)) begin
            rdata = '0;
        end else begin
            rdata = rf_q;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/rf_multiport.sv
`default_nettype none
// ============================================================================
//  Module   : rf_multiport
//  Purpose  : NR-read / NW-write register file with x0 hardwired to zero and
//             a sequential clear sweep. Optional bypass: RF_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_multiport
    import rf_pkg::*;
#(
    parameter int RFW = RF_RFW,
    parameter int DW  = RF_DW,
    parameter int NR  = RF_NR,
    parameter int NW  = RF_NW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              ready,
    input  logic [NW-1:0]     we,
    input  logic [NW*RFW-1:0] waddr,
    input  logic [NW*DW-1:0]  wdata,
    input  logic [NR*RFW-1:0] raddr,
    output logic [NR*DW-1:0]  rdata
);

    localparam int c_depth = 2**RFW;

    rf_state_t      r_state;
    logic [RFW-1:0] r_cnt;
    logic           r_ready;
    logic [DW-1:0]  r_rf [c_depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (clr) begin
                        r_cnt <= '0;
                    end else if (r_cnt == '1) begin
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        r_cnt   <= '0;
                        r_state <= ST_CLEAR;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage carries no reset; the sweep is what establishes its contents.
    // Later loop iterations override earlier ones, so the higher port wins.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_rf[r_cnt] <= '0;
        end else if (r_ready && !clr) begin
            for (int k = 0; k < NW; k++) begin
                if (we[k] && (waddr[k*RFW +: RFW] != '0)) begin
                    r_rf[waddr[k*RFW +: RFW]] <= wdata[k*DW +: DW];
                end
            end
        end
    end

    assign ready = r_ready;

    generate
        for (genvar j = 0; j < NR; j++) begin : g_rd
            logic [DW-1:0] w_rf_q;

            assign w_rf_q = r_rf[raddr[j*RFW +: RFW]];

            rf_read_sel #(
                .RFW (RFW),
                .DW  (DW),
                .NW  (NW)
            ) u_rd (
                .ready (r_ready),
                .raddr (raddr[j*RFW +: RFW]),
                .rf_q  (w_rf_q),
`ifdef RF_BYPASS_EN
                .we    (we),
                .waddr (waddr),
                .wdata (wdata),
`endif
                .rdata (rdata[j*DW +: DW])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rf_multiport.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_multiport
//  Purpose  : Directed self-checking bench for rf_multiport (NR=2, NW=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_multiport;

`ifdef RF_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        ready;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    rf_multiport #(
        .RFW (5),
        .DW  (32),
        .NR  (2),
        .NW  (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .ready (ready),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
        we[p]            = 1'b1;
        waddr[p*5 +: 5]  = a;
        wdata[p*32 +: 32] = d;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = '0; waddr = '0; wdata = '0;
        raddr = {5'd2, 5'd1};

        // Reset and initial sweep
        repeat (3) tick();
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        rst = 1'b0;
        #1;
        chk("sweep_ready_low", {63'd0, ready}, 64'd0);
        wait_ready(n);
        chk("sweep_len", 64'(n), 64'd32);
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(31 - a), 5'(a)};
            #1;
            chk("swept_rd0", {32'd0, rdata[31:0]}, 64'd0);
            chk("swept_rd1", {32'd0, rdata[63:32]}, 64'd0);
        end

        // Basic write / read, x0 stays zero
        raddr = {5'd0, 5'd5};
        set_wr(0, 5'd5, 32'hDEADBEEF);
        #1;
        chk("wr5_same", {32'd0, rdata[31:0]}, c_byp ? 64'hDEADBEEF : 64'd0);
        tick();
        we = '0;
        #1;
        chk("wr5_next", {32'd0, rdata[31:0]}, 64'hDEADBEEF);
        set_wr(0, 5'd0, 32'h1234);
        raddr = {5'd5, 5'd0};
        #1;
        chk("x0_same", {32'd0, rdata[31:0]}, 64'd0);
        tick();
        we = '0;
        #1;
        chk("x0_next", {32'd0, rdata[31:0]}, 64'd0);
        chk("x5_hold", {32'd0, rdata[63:32]}, 64'hDEADBEEF);

        // Write collision on x7: port 1 wins
        raddr = {5'd7, 5'd7};
        set_wr(0, 5'd7, 32'h11);
        set_wr(1, 5'd7, 32'h22);
        #1;
        chk("coll_same", {32'd0, rdata[63:32]}, c_byp ? 64'h22 : 64'd0);
        tick();
        we = '0;
        #1;
        chk("coll_next", {32'd0, rdata[31:0]}, 64'h22);

        // Bypass on/off with a nonzero old value in x9
        set_wr(1, 5'd9, 32'h1111);
        tick();
        we = '0;
        raddr = {5'd9, 5'd5};
        set_wr(0, 5'd9, 32'hA5A5A5A5);
        #1;
        chk("byp_same", {32'd0, rdata[63:32]}, c_byp ? 64'hA5A5A5A5 : 64'h1111);
        chk("byp_other", {32'd0, rdata[31:0]}, 64'hDEADBEEF);
        tick();
        we = '0;
        #1;
        chk("byp_next", {32'd0, rdata[63:32]}, 64'hA5A5A5A5);

        // clr together with a write
        set_wr(0, 5'd3, 32'h55);
        tick();
        we = '0;
        raddr = {5'd4, 5'd3};
        #1;
        chk("x3_load", {32'd0, rdata[31:0]}, 64'h55);
        clr = 1'b1;
        set_wr(0, 5'd4, 32'h66);
        #1;
        chk("clr_ready_pre", {63'd0, ready}, 64'd1);
        tick();
        clr = 1'b0;
        we = '0;
        #1;
        chk("clr_ready_drop", {63'd0, ready}, 64'd0);
        chk("clr_rd_mask", {32'd0, rdata[31:0]}, 64'd0);
        wait_ready(n);
        chk("clr_sweep_len", 64'(n), 64'd32);
        chk("clr_x3", {32'd0, rdata[31:0]}, 64'd0);
        chk("clr_x4", {32'd0, rdata[63:32]}, 64'd0);

        // Reset mid-sweep at cnt=10, writes blocked during the sweep
        set_wr(0, 5'd12, 32'hCAFE);
        tick();
        we = '0;
        raddr = {5'd5, 5'd12};
        #1;
        chk("x12_load", {32'd0, rdata[31:0]}, 64'hCAFE);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {63'd0, ready}, 64'd0);
        chk("mid_rst_rdata", rdata, 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        set_wr(0, 5'd12, 32'hBAD0);
        set_wr(1, 5'd20, 32'hBAD1);
        wait_ready(n);
        chk("rst_sweep_len", 64'(n), 64'd32);
        we = '0;
        raddr = {5'd20, 5'd12};
        #1;
        chk("sweep_wr_x12", {32'd0, rdata[31:0]}, 64'd0);
        chk("sweep_wr_x20", {32'd0, rdata[63:32]}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the single-write, dual-read register file.
- Provides NR combinational read ports and NW clocked write ports, with fixed write-port priority and x0 hardwired to zero.
- Adds a sequential clear engine that sweeps every entry after reset or on request, and an optional same-cycle write-to-read bypass.
- Sits between decode (reads) and writeback (writes) in the pipelined core.

Parameters:
- RFW, 5, address width; depth = 2**RFW entries.
- DW, 32, data width.
- NR, 2, number of read ports (1..4).
- NW, 1, number of write ports (1..2).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous request to re-run the clear sweep.
- ready  out  1  high when the file is usable; low during a sweep.
- we  in  NW  per-port write enable.
- waddr  in  NW*RFW  write addresses; port k at [k*RFW +: RFW].
- wdata  in  NW*DW  write data; port k at [k*DW +: DW].
- raddr  in  NR*RFW  read addresses; port j at [j*RFW +: RFW].
- rdata  out  NR*DW  read data; port j at [j*DW +: DW].

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=CLEAR, sweep counter cnt=0, ready=0, rdata=0. Array contents are don't-care until the sweep completes.
- FSM has two states, CLEAR and RUN.
  - CLEAR: each posedge writes 0 to rf[cnt] and increments cnt. The edge that clears entry 2**RFW-1 moves the FSM to RUN and sets ready=1. Sweep latency after rst deassertion is exactly 2**RFW cycles.
  - RUN: clr=1 at a posedge moves the FSM to CLEAR with cnt=0 and ready=0 from that edge onward.
  - clr=1 while already in CLEAR restarts the sweep at cnt=0.
- Writes in RUN: rf[waddr_k] <= wdata_k at posedge when we[k]=1.
  - waddr_k==0 is dropped.
  - Same address on two ports in one cycle: the higher-index port wins.
- Writes while ready=0, or in the cycle clr=1, are ignored; the sweep has priority.
- Reads are combinational. rdata_j = rf[raddr_j], except:
  - raddr_j==0 returns 0;
  - ready=0 returns 0.
- Without bypass, a write is visible on rdata only after the posedge that performs it.
- Reads never stall and have no handshake. ready is the only flow-control signal, and the pipeline must hold decode while ready=0.
- rst asserted mid-sweep or mid-write aborts immediately; the sweep restarts from entry 0 after deassertion.
- Write timing is posedge with no #delay. The negedge write scheme is retired.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: in RUN, if we[k]=1, waddr_k==raddr_j and raddr_j!=0, rdata_j = wdata_k in the same cycle. With multiple matches the highest k wins, consistent with write priority. Bypass is suppressed when ready=0.
- Undefined: no bypass; rdata reflects the stored value only. The forwarding unit upstream must cover the hazard.

Decomposition:
- Package rf_pkg holds:
  - state enum (CLEAR, RUN);
  - default constants RF_RFW=5, RF_DW=32, RF_NR=2, RF_NW=1;
  - a helper function returning the winning write-port index for a given address.
- One sub-module, rf_read_sel, is instantiated once per read port. It applies zero-register masking, ready masking and (under RF_BYPASS_EN) bypass selection.
- Storage array, sweep counter and FSM live in rf_multiport.

Test Plan:
1. Reset and sweep: pulse rst for 3 cycles, then release.
   - ready stays 0 for exactly 32 posedges, then goes 1.
   - All 32 addresses read 0 afterwards.
2. Basic write/read: in RUN, write x5=0xDEADBEEF.
   - Next cycle rdata0 with raddr0=5 returns 0xDEADBEEF.
   - Write x0=0x1234; reading x0 returns 0.
3. Write collision: NW=2, both ports write x7 (port0=0x11, port1=0x22) in the same cycle.
   - x7 reads 0x22.
   - With RF_BYPASS_EN, rdata shows 0x22 in the write cycle itself.
4. Bypass on/off: write x9=0xA5A5A5A5 while raddr1=9 in the same cycle.
   - With the macro: rdata1=0xA5A5A5A5 that cycle.
   - Without it: old value that cycle, 0xA5A5A5A5 the next cycle.
5. clr during writes: load x3=0x55, then assert clr together with we to x4=0x66.
   - ready drops the next cycle.
   - After 32 cycles, x3=0 and x4=0.
6. Reset mid-sweep: assert rst at cnt=10, release.
   - Sweep restarts from 0; ready rises exactly 32 cycles after release.
   - Writes attempted during the sweep have no effect.
